// File: rtl/bp_me_pkg.sv
// Shared types for the CCE speculative-access table: coherence states,
// the per-way-group entry layout, the table FSM states and a field-merge helper.
package bp_me_pkg;

    // Coherence states carried in the forwarded-state field
    typedef enum logic [2:0] {
        e_COH_I = 3'b000,
        e_COH_S = 3'b001,
        e_COH_E = 3'b010,
        e_COH_F = 3'b011,
        e_COH_M = 3'b110,
        e_COH_O = 3'b111
    } bp_coh_states_e;

    // One table entry; field order fixes the bit layout used by the write mask
    typedef struct packed {
        logic           spec;
        logic           squash;
        logic           fwd_mod;
        bp_coh_states_e state;
    } bp_cce_spec_s;

    typedef enum logic [1:0] {
        e_reset = 2'd0,
        e_clear = 2'd1,
        e_ready = 2'd2
    } bp_cce_spec_table_state_e;

    localparam int spec_entry_width_lp = $bits(bp_cce_spec_s);
    localparam int coh_state_width_lp  = $bits(bp_coh_states_e);

    // Value every entry holds after the clear sweep
    localparam bp_cce_spec_s spec_entry_clear_lp = '{
        spec    : 1'b0,
        squash  : 1'b0,
        fwd_mod : 1'b0,
        state   : e_COH_I
    };

    // Bits set in mask take the new entry, the rest keep the old entry
    function automatic bp_cce_spec_s spec_merge(
        input bp_cce_spec_s                   old_entry,
        input bp_cce_spec_s                   new_entry,
        input logic [spec_entry_width_lp-1:0] mask
    );
        return bp_cce_spec_s'((old_entry & ~mask) | (new_entry & mask));
    endfunction

    // Expands the four per-field write enables into a per-bit entry mask
    function automatic logic [spec_entry_width_lp-1:0] spec_field_mask(
        input logic spec_en,
        input logic squash_en,
        input logic fwd_mod_en,
        input logic state_en
    );
        return {spec_en, squash_en, fwd_mod_en, {coh_state_width_lp{state_en}}};
    endfunction

endpackage

// File: rtl/bp_cce_spec_table_if.sv
// Access bus of the speculative-access table: one write port with per-field
// enables, one read port with a registered result, and the ready flag.
interface bp_cce_spec_table_if #(
    parameter int paddr_width_p = 40
) ();
    import bp_me_pkg::*;

    logic                     ready_o;

    logic                     w_v_i;
    logic [paddr_width_p-1:0] w_addr_i;
    logic                     spec_w_v_i;
    logic                     squash_w_v_i;
    logic                     fwd_mod_w_v_i;
    logic                     state_w_v_i;
    logic                     spec_i;
    logic                     squash_i;
    logic                     fwd_mod_i;
    bp_coh_states_e           state_i;

    logic                     r_v_i;
    logic [paddr_width_p-1:0] r_addr_i;

    logic                     r_v_o;
    logic                     spec_o;
    logic                     squash_o;
    logic                     fwd_mod_o;
    bp_coh_states_e           state_o;

    // Requester side (memory-response path / ucode)
    modport master (
        input  ready_o,
        output w_v_i, w_addr_i,
        output spec_w_v_i, squash_w_v_i, fwd_mod_w_v_i, state_w_v_i,
        output spec_i, squash_i, fwd_mod_i, state_i,
        output r_v_i, r_addr_i,
        input  r_v_o, spec_o, squash_o, fwd_mod_o, state_o
    );

    // Table side
    modport slave (
        output ready_o,
        input  w_v_i, w_addr_i,
        input  spec_w_v_i, squash_w_v_i, fwd_mod_w_v_i, state_w_v_i,
        input  spec_i, squash_i, fwd_mod_i, state_i,
        input  r_v_i, r_addr_i,
        output r_v_o, spec_o, squash_o, fwd_mod_o, state_o
    );

endinterface

// File: rtl/bsg_mem_1r1w.sv
// Unreset storage array with one bit-masked synchronous write port and one
// asynchronous read port. The caller registers the read data.
module bsg_mem_1r1w #(
    parameter int width_p = 6,
    parameter int els_p   = 64,
    parameter int lg_els_lp = $clog2(els_p)
) (
    input  logic                 clk_i,

    input  logic                 w_v_i,
    input  logic [lg_els_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]   w_data_i,
    input  logic [width_p-1:0]   w_mask_i,

    input  logic [lg_els_lp-1:0] r_addr_i,
    output logic [width_p-1:0]   r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    // Only bits selected by the mask are written; the rest of the word keeps its contents
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            for (int b = 0; b < width_p; b++) begin
                if (w_mask_i[b]) begin
                    mem_q[w_addr_i][b] <= w_data_i[b];
                end
            end
        end
    end

    // els_p is a power of two, so every address is in range
    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_cce_spec_table.sv
// Per-way-group speculative-access state table. After reset it sweeps every
// entry to the cleared value, then serves one read and one write per cycle.
// Reads are registered and see a same-cycle write to the same entry.
module bp_cce_spec_table
    import bp_me_pkg::*;
#(
    parameter int num_way_groups_p      = 64,
    parameter int paddr_width_p         = 40,
    parameter int block_size_in_bytes_p = 64
) (
    input  logic                clk_i,
    input  logic                reset_i,
    bp_cce_spec_table_if.slave  bus
);

    localparam int lg_block_lp = $clog2(block_size_in_bytes_p);
    localparam int lg_sets_lp  = $clog2(num_way_groups_p);
    localparam logic [lg_sets_lp-1:0] last_idx_lp = lg_sets_lp'(num_way_groups_p - 1);

    // ------------------------------------------------------------------
    // Index extraction; bits above the index field alias onto one entry
    // ------------------------------------------------------------------
    logic [paddr_width_p-1:0] w_addr;
    logic [paddr_width_p-1:0] r_addr;
    logic [lg_sets_lp-1:0]    w_idx;
    logic [lg_sets_lp-1:0]    r_idx;
    logic                     unused_addr_bits;

    assign w_addr = bus.w_addr_i;
    assign r_addr = bus.r_addr_i;
    assign w_idx  = w_addr[lg_block_lp +: lg_sets_lp];
    assign r_idx  = r_addr[lg_block_lp +: lg_sets_lp];
    // Offset and tag bits are intentionally ignored
    assign unused_addr_bits = ^{w_addr, r_addr};

    // ------------------------------------------------------------------
    // Initialisation FSM with clear sweep
    // ------------------------------------------------------------------
    bp_cce_spec_table_state_e state_q;
    logic [lg_sets_lp-1:0]    clear_idx_q;
    logic                     ready_q;

    // Sequence reset -> clear every index once -> ready until the next reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= e_reset;
            clear_idx_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            unique case (state_q)
                e_reset: begin
                    state_q     <= e_clear;
                    clear_idx_q <= '0;
                end
                e_clear: begin
                    clear_idx_q <= clear_idx_q + lg_sets_lp'(1);
                    if (clear_idx_q == last_idx_lp) begin
                        state_q <= e_ready;
                        ready_q <= 1'b1;
                    end
                end
                e_ready: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= e_reset;
                    clear_idx_q <= '0;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // External write: per-field mask, gated by ready
    // ------------------------------------------------------------------
    logic                           ext_w_v;
    logic                           clearing;
    bp_cce_spec_s                   w_entry;
    logic [spec_entry_width_lp-1:0] w_mask;

    assign ext_w_v  = ready_q & bus.w_v_i;
    assign clearing = (state_q == e_clear);
    assign w_mask   = spec_field_mask(bus.spec_w_v_i, bus.squash_w_v_i,
                                      bus.fwd_mod_w_v_i, bus.state_w_v_i)
                      & {spec_entry_width_lp{ext_w_v}};

    // Pack the incoming field data into an entry
    always_comb begin
        w_entry         = spec_entry_clear_lp;
        w_entry.spec    = bus.spec_i;
        w_entry.squash  = bus.squash_i;
        w_entry.fwd_mod = bus.fwd_mod_i;
        w_entry.state   = bus.state_i;
    end

    // ------------------------------------------------------------------
    // Storage write port: clear sweep has priority (external writes are
    // already gated off while not ready)
    // ------------------------------------------------------------------
    logic                           mem_w_v;
    logic [lg_sets_lp-1:0]          mem_w_addr;
    logic [spec_entry_width_lp-1:0] mem_w_data;
    logic [spec_entry_width_lp-1:0] mem_w_mask;
    logic [spec_entry_width_lp-1:0] mem_r_data;

    // Select between the clear sweep and the masked external write
    always_comb begin
        mem_w_v    = 1'b0;
        mem_w_addr = w_idx;
        mem_w_data = w_entry;
        mem_w_mask = w_mask;
        if (clearing) begin
            mem_w_v    = 1'b1;
            mem_w_addr = clear_idx_q;
            mem_w_data = spec_entry_clear_lp;
            mem_w_mask = '1;
        end else if (ext_w_v) begin
            mem_w_v    = 1'b1;
        end
    end

    bsg_mem_1r1w #(
        .width_p (spec_entry_width_lp),
        .els_p   (num_way_groups_p)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (mem_w_v),
        .w_addr_i (mem_w_addr),
        .w_data_i (mem_w_data),
        .w_mask_i (mem_w_mask),
        .r_addr_i (r_idx),
        .r_data_o (mem_r_data)
    );

    // ------------------------------------------------------------------
    // Read path with write-first bypass and output register
    // ------------------------------------------------------------------
    logic         r_fire;
    logic         bypass;
    bp_cce_spec_s r_entry_d;
    bp_cce_spec_s r_entry_q;
    logic         r_v_q;

    assign r_fire = ready_q & bus.r_v_i;
    assign bypass = ext_w_v & (w_idx == r_idx);

    // A same-index write overlays only its enabled fields on the stored entry
    always_comb begin
        r_entry_d = spec_merge(bp_cce_spec_s'(mem_r_data), w_entry,
                               bypass ? w_mask : '0);
    end

    // Capture the read result; fields hold when no read is issued
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_v_q     <= 1'b0;
            r_entry_q <= spec_entry_clear_lp;
        end else begin
            r_v_q <= r_fire;
            if (r_fire) begin
                r_entry_q <= r_entry_d;
            end
        end
    end

    assign bus.ready_o   = ready_q;
    assign bus.r_v_o     = r_v_q;
    assign bus.spec_o    = r_entry_q.spec;
    assign bus.squash_o  = r_entry_q.squash;
    assign bus.fwd_mod_o = r_entry_q.fwd_mod;
    assign bus.state_o   = r_entry_q.state;

    // Flag requests that arrive before initialisation completes (they are dropped)
    always_ff @(posedge clk_i) begin
        if (!reset_i && !ready_q) begin
            assert (!(bus.w_v_i || bus.r_v_i))
            else $warning("spec table access while not ready is ignored");
        end
    end

endmodule

// File: doc/bp_cce_spec_table.md
# bp_cce_spec_table

Per-way-group speculative-access state table for the CCE. Holds, for each way-group, the speculative bit, squash bit, forward-modified bit and forwarded coherence state written by the memory-response path and the ucode spec-write instruction. Sits directly upstream of `bp_cce_reg`. Its registered `spec_o` read result drives that block's `spec_sf_i` input, and the other fields feed the memory-response datapath.

## Interface
- `num_way_groups_p`, 64: table entries; power of two, ≥2.
- `paddr_width_p`, 40: physical address width.
- `block_size_in_bytes_p`, 64: cache block size; index starts at bit `lg_block_size_in_bytes`.
- `clk_i` in 1: clock. Single clock domain.
- `reset_i` in 1: reset; asynchronous, active-high.
- `ready_o` out 1: table initialised and accepting ops.
- `w_v_i` in 1: write valid.
- `w_addr_i` in paddr_width_p: write address; index = `w_addr_i[lg_block +: lg_num_way_groups]`.
- `spec_w_v_i`, `squash_w_v_i`, `fwd_mod_w_v_i`, `state_w_v_i` in 1 each: per-field write enables. Only meaningful with `w_v_i`.
- `spec_i`, `squash_i`, `fwd_mod_i` in 1 each: field write data.
- `state_i` in `$bits(bp_coh_states_e)`: forwarded coherence state write data.
- `r_v_i` in 1: read valid.
- `r_addr_i` in paddr_width_p: read address; same index slice.
- `r_v_o` out 1: read data valid, one cycle after `r_v_i`.
- `spec_o`, `squash_o`, `fwd_mod_o` out 1 each: read fields.
- `state_o` out `bp_coh_states_e`: read forwarded state.

## Operation
FSM states:
- `e_reset`: entered asynchronously on `reset_i`. Moves to `e_clear` on the first clock edge after deassertion.
- `e_clear`: a clear counter sweeps index 0..num_way_groups_p-1, one entry per cycle. Each entry is written all-zero: spec=0, squash=0, fwd_mod=0, state=e_COH_I. After the last index, the FSM moves to `e_ready`.
- `e_ready`: `ready_o`=1. Terminal until the next reset.

Rules:
- While not ready, `w_v_i` and `r_v_i` are ignored, `r_v_o` stays 0, and a simulation assertion fires if either is high.
- Write: each field updates only if both `w_v_i` and its own enable are set. Unenabled fields keep their values. `w_v_i` with no enables set is a no-op.
- Read: the entry is registered. `r_v_o` and the fields are valid the cycle after `r_v_i`. Output fields hold their last value while `r_v_i`=0, and `r_v_o` drops to 0 in that case.
- Read and write to the same index in the same cycle is write-first: the read output reflects the merged post-write entry.
- Reads and writes to different indices in the same cycle are independent.
- Index wraps naturally. Address bits above the index field are ignored, so aliasing addresses share an entry.

## Timing
- Reset values: `ready_o`=0, `r_v_o`=0, `spec_o`=`squash_o`=`fwd_mod_o`=0, `state_o`=e_COH_I. The FSM and clear counter are reset to 0.
- Reset mid-operation: all of the above reset values apply immediately, whatever the current state. Any write in flight in that cycle is lost, and the clear sweep restarts from 0.
- `ready_o` rises exactly num_way_groups_p+1 cycles after the first edge on which `reset_i` is low (1 cycle for `e_reset`, then N clear cycles).
- Read latency is 1 cycle. Write latency is 1 cycle: a write at cycle t is visible to a read issued at t (bypass) or later.
- There is no backpressure. In `e_ready` one read and one write are accepted every cycle.

## Structure
- `bp_cce_spec_s` goes in `bp_me_pkg`: packed struct {spec, squash, fwd_mod, state (bp_coh_states_e)}.
- `bp_cce_spec_table_state_e` goes in `bp_me_pkg`: {e_reset, e_clear, e_ready}.
- Storage is a single sub-module, `bsg_mem_1r1w`: num_way_groups_p × `$bits(bp_cce_spec_s)`, with an asynchronous read feeding the local output register. The write port is muxed between the clear sweep and the external write.
- Field merge and write-first bypass live in the top level. The storage array has no reset.

## Test plan
- Reset, init, and rejected accesses:
  - Stimulus: N=64; deassert reset, then assert `r_v_i` during clear.
  - Required: `ready_o`=0 for 65 cycles, then 1; assertion fires; `r_v_o` stays 0.
- Clear sweep:
  - Stimulus: after ready, read every index 0..63 via `r_addr_i = idx<<6`.
  - Required: every read returns all fields 0 and `state_o`=e_COH_I.
- Partial write:
  - Stimulus: write addr 0x1C0 (idx 7) with spec=1, state=e_COH_M and only `spec_w_v_i`+`state_w_v_i` set; then write squash=1 with only `squash_w_v_i` set.
  - Required: a read of 0x1C0 returns spec=1, squash=1, fwd_mod=0, state=e_COH_M.
- Same-cycle bypass:
  - Stimulus: idx 3 holds spec=1; in one cycle write spec=0 (`spec_w_v_i`) and read idx 3.
  - Required: next cycle `r_v_o`=1, `spec_o`=0.
- Aliasing / wrap:
  - Stimulus: write spec=1 to 0x0040; read 0x1000_0040.
  - Required: `spec_o`=1 (same idx 1). A read of 0x0080 returns `spec_o`=0.
- Mid-operation reset:
  - Stimulus: assert `reset_i` asynchronously during `e_ready` with a pending write, then release.
  - Required: outputs go to reset values immediately; a full clear rerun follows; the written entry reads 0.
